// File: rtl/trig_event_readout_pkg.sv
// rtl/trig_event_readout_pkg.sv - shared constants and state encoding for the event readout engine
package trig_event_readout_pkg;

    localparam int RDY_BIT_DEF     = 0;
    localparam int NUM_WORDS_DEF   = 8;
    localparam int CLR_HOLDOFF_DEF = 4;
    localparam int ADDR_W          = 6;
    localparam int HOLD_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CAPT    = 3'd2,
        ST_SEND    = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_e;

endpackage

// File: rtl/trig_readout_holdoff.sv
// rtl/trig_readout_holdoff.sv - loadable down-counter timing the post-clear holdoff
module trig_readout_holdoff
    import trig_event_readout_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              done_o
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted on the final holdoff cycle, i.e. the decrement that reaches zero.
    assign done_o = (count_q <= HOLD_W'(1));

endmodule

// File: rtl/trig_event_readout.sv
// rtl/trig_event_readout.sv - drains completed event headers from the buffer onto a valid/ready stream
module trig_event_readout
    import trig_event_readout_pkg::*;
#(
    parameter int NUM_WORDS   = NUM_WORDS_DEF,
    parameter int CLR_HOLDOFF = CLR_HOLDOFF_DEF,
    parameter int RDY_BIT     = RDY_BIT_DEF
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [31:0] status_i,
    output logic [5:0]  event_addr_o,
    input  logic [31:0] event_dat_i,
    output logic        clr_evt_o,
    output logic [31:0] dout_o,
    output logic        dout_valid_o,
    output logic        dout_last_o,
    input  logic        dout_ready_i,
    output logic [15:0] evt_count_o,
    output logic        busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    // Status is resampled exactly CLR_HOLDOFF cycles after the clear pulse; the CLEAR
    // cycle itself counts as one of them, hence the load of CLR_HOLDOFF-1.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLR_HOLDOFF - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [15:0]       evt_count_q, evt_count_d;
    logic              hold_load;
    logic              hold_dec;
    logic              hold_done;

    trig_readout_holdoff u_holdoff (
        .clk_i      (clk33_i),
        .rst_i      (rst_i),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (hold_dec),
        .done_o     (hold_done)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        last_d      = last_q;
        evt_count_d = evt_count_q;
        hold_load   = 1'b0;
        hold_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && status_i[RDY_BIT]) begin
                    state_d = ST_ADDR;
                    addr_d  = '0;
                end
            end
            ST_ADDR: state_d = ST_CAPT;
            ST_CAPT: begin
                dout_d  = event_dat_i;
                valid_d = 1'b1;
                last_d  = (addr_q == LAST_ADDR);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_CLEAR: begin
                evt_count_d = evt_count_q + 16'd1;
                hold_load   = 1'b1;
                state_d     = (CLR_HOLDOFF > 1) ? ST_HOLDOFF : ST_IDLE;
            end
            ST_HOLDOFF: begin
                hold_dec = 1'b1;
                if (hold_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            evt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            evt_count_q <= evt_count_d;
        end
    end

    assign event_addr_o = addr_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign evt_count_o  = evt_count_q;
    assign clr_evt_o    = (state_q == ST_CLEAR);
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trig_event_readout.sv
// tb/tb_trig_event_readout.sv - scoreboard bench for trig_event_readout
module tb_trig_event_readout;
    import trig_event_readout_pkg::*;

    localparam int NW = 8;
    localparam int HO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] status = '0;
    logic        ready = 1'b1;

    logic [5:0]  addr0, addr1;
    logic [31:0] dat0, dat1, dout0, dout1;
    logic        clr0, clr1, valid0, valid1, last0, last1, busy0, busy1;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    trig_event_readout #(.NUM_WORDS(NW), .CLR_HOLDOFF(HO), .RDY_BIT(0)) u_dut0 (
        .clk33_i(clk), .rst_i(rst), .enable_i(enable), .status_i(status),
        .event_addr_o(addr0), .event_dat_i(dat0), .clr_evt_o(clr0),
        .dout_o(dout0), .dout_valid_o(valid0), .dout_last_o(last0),
        .dout_ready_i(ready), .evt_count_o(cnt0), .busy_o(busy0)
    );

    trig_event_readout #(.NUM_WORDS(1), .CLR_HOLDOFF(1), .RDY_BIT(0)) u_dut1 (
        .clk33_i(clk), .rst_i(rst), .enable_i(enable), .status_i(status),
        .event_addr_o(addr1), .event_dat_i(dat1), .clr_evt_o(clr1),
        .dout_o(dout1), .dout_valid_o(valid1), .dout_last_o(last1),
        .dout_ready_i(ready), .evt_count_o(cnt1), .busy_o(busy1)
    );

    // Registered event buffers: word n holds 0xA5000000+n
    always @(posedge clk) begin
        dat0 <= 32'hA500_0000 + {26'd0, addr0};
        dat1 <= 32'hA500_0000 + {26'd0, addr1};
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] dat;
        logic        last;
        logic [5:0]  addr;
        int          due;
    } exp_t;

    exp_t        q0[$];
    logic [15:0] exp_evt = '0;

    // Reference model: an event is a fixed block of NW words, started whenever the
    // engine is free, enabled and the ready flag is set; free again HO cycles after clear.
    bit m_busy = 1'b0;
    int m_free = 0;
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            m_busy = 1'b0;
            m_free = 0;
        end else begin
            check(busy0 == (m_busy || cyc < m_free), "busy", {31'd0, busy0}, {31'd0, (m_busy || cyc < m_free)});
            if (clr0) begin
                m_busy = 1'b0;
                m_free = cyc + HO;
            end
            if (!m_busy && cyc >= m_free && enable && status[0]) begin
                for (int i = 0; i < NW; i++) begin
                    exp_t e;
                    e.dat  = 32'hA500_0000 + i;
                    e.last = (i == NW - 1);
                    e.addr = 6'(i);
                    e.due  = (i == 0) ? cyc + 3 : -1;
                    q0.push_back(e);
                end
                m_busy = 1'b1;
            end
        end
    end

    // Monitor: pops expected words as the DUT presents them
    bit          rst_prev = 1'b0;
    int          exp_clr_at = -1;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_dout;
    logic [5:0]  prev_addr;
    always @(negedge clk) begin
        if (rst) begin
            rst_prev   = 1'b1;
            exp_clr_at = -1;
            exp_evt    = '0;
            stall_prev = 1'b0;
        end else begin
            if (rst_prev) begin
                check({addr0, dout0, valid0, last0, clr0, busy0, cnt0} == '0, "reset_outputs",
                      {dout0[15:0], cnt0}, 32'd0);
                rst_prev = 1'b0;
            end
            check(clr0 == (cyc == exp_clr_at), "clr_pulse", {31'd0, clr0}, {31'd0, (cyc == exp_clr_at)});
            check(cnt0 == exp_evt, "evt_count", {16'd0, cnt0}, {16'd0, exp_evt});
            if (clr0) exp_evt = exp_evt + 16'd1;
            if (stall_prev) begin
                check(valid0 && dout0 == prev_dout && addr0 == prev_addr, "stall_hold",
                      {valid0, addr0, dout0[24:0]}, {1'b1, prev_addr, prev_dout[24:0]});
            end
            if (valid0) begin
                if (q0.size() == 0) begin
                    check(1'b0, "unexpected_word", dout0, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = q0[0];
                    check(dout0 == e.dat, "dout", dout0, e.dat);
                    check(last0 == e.last, "dout_last", {31'd0, last0}, {31'd0, e.last});
                    check(addr0 == e.addr, "event_addr", {26'd0, addr0}, {26'd0, e.addr});
                    if (e.due >= 0) begin
                        check(cyc == e.due, "first_valid_latency", cyc, e.due);
                        q0[0].due = -1;
                    end
                    if (ready) begin
                        void'(q0.pop_front());
                        if (e.last) exp_clr_at = cyc + 1;
                    end
                end
            end
            stall_prev = valid0 && !ready;
            prev_dout  = dout0;
            prev_addr  = addr0;
        end
    end

    // Single-word build: every word is the last one and is word 0
    int n_hs1 = 0;
    int n_clr1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            n_hs1  = 0;
            n_clr1 = 0;
        end else begin
            if (valid1) begin
                check(last1 && dout1 == 32'hA500_0000 && addr1 == 6'd0, "nw1_word", dout1, 32'hA500_0000);
                if (ready) n_hs1++;
            end
            if (clr1) n_clr1++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input logic [5:0] a, input string name);
        int t;
        t = 0;
        while (!(valid0 && addr0 == a) && t < 300) begin
            tick(1);
            t++;
        end
        if (t >= 300) check(1'b0, name, {26'd0, addr0}, {26'd0, a});
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy0 || busy1) && t < 300) begin
            tick(1);
            t++;
        end
        if (t >= 300) check(1'b0, name, {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        int t;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Back-to-back events with status permanently ready
        enable = 1'b1;
        status = 32'h1;
        ready  = 1'b1;
        t = 0;
        while (cnt0 != 16'd3 && t < 300) begin
            tick(1);
            t++;
        end
        status = 32'h0;
        check(cnt0 == 16'd3, "three_events", {16'd0, cnt0}, 32'd3);
        wait_idle("idle_after_b2b");

        // Backpressure on word 3
        status = 32'hFFFF_FFFF;
        wait_word(6'd3, "bp_wait_word3");
        status = 32'h0;
        ready  = 1'b0;
        tick(5);
        ready  = 1'b1;
        wait_idle("idle_after_bp");

        // Enable dropped during word 2
        status = 32'h1;
        wait_word(6'd2, "en_wait_word2");
        enable = 1'b0;
        tick(60);
        check(busy0 == 1'b0, "stays_idle_disabled", {31'd0, busy0}, 32'd0);
        enable = 1'b1;
        tick(40);
        status = 32'h0;
        wait_idle("idle_after_enable");

        // Reset during word 4
        status = 32'h1;
        wait_word(6'd4, "rst_wait_word4");
        status = 32'h0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check(cnt0 == 16'd0 && !busy0 && !clr0, "after_reset", {16'd0, cnt0}, 32'd0);

        // Event counter wrap
        wait_idle("idle_before_wrap");
        enable = 1'b0;
        tick(2);
        force u_dut0.evt_count_q = 16'hFFFF;
        exp_evt = 16'hFFFF;
        #2;
        release u_dut0.evt_count_q;
        tick(2);
        enable = 1'b1;
        status = 32'h1;
        wait_word(6'd0, "wrap_wait_start");
        status = 32'h0;
        wait_idle("idle_after_wrap");
        tick(2);
        check(cnt0 == 16'h0000, "evt_count_wrap", {16'd0, cnt0}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ready  = ($urandom_range(0, 3) != 0);
            status = {$urandom, 1'b0} | {31'd0, ($urandom_range(0, 2) != 0)};
            enable = ($urandom_range(0, 7) != 0);
            tick(1);
        end

        enable = 1'b0;
        ready  = 1'b1;
        wait_idle("final_drain");
        tick(3);
        check(q0.size() == 0, "scoreboard_empty", q0.size(), 32'd0);
        check(n_hs1 > 0 && n_hs1 == int'(cnt1) && n_clr1 == int'(cnt1), "nw1_events", n_hs1, {16'd0, cnt1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
